sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO; next-generation replacement for the fixed 8-bit x 16 FIFO
//  behind fifo_if. Adds configurable width/depth, almost-full/almost-empty thresholds,
//  overflow/underflow error pulses and optional first-word-fall-through (FWFT) read mode.
//  Sits between the write-side driver and the read-side consumer in the FIFO BFM testbench.
// PARAMETERS
//  DATA_W     8         data word width in bits
//  DEPTH      16        number of entries; power of two, >= 4
//  AF_THRESH  DEPTH-2   almost_full asserts when fifo_cnt >= AF_THRESH
//  AE_THRESH  2         almost_empty asserts when fifo_cnt <= AE_THRESH
//  FWFT       0         0 = registered read (1-cycle latency), 1 = first-word-fall-through
// PORTS
//  clk           in   1                     clock; all logic on rising edge
//  rst           in   1                     synchronous, active-high reset
//  data_in       in   DATA_W                write data
//  wr            in   1                     write request
//  rd            in   1                     read request
//  data_out      out  DATA_W                read data
//  empty         out  1                     fifo_cnt == 0
//  full          out  1                     fifo_cnt == DEPTH
//  almost_empty  out  1                     fifo_cnt <= AE_THRESH
//  almost_full   out  1                     fifo_cnt >= AF_THRESH
//  fifo_cnt      out  $clog2(DEPTH)+1       current occupancy, 0..DEPTH
//  overflow      out  1                     1-cycle pulse: write rejected
//  underflow     out  1                     1-cycle pulse: read rejected
// BEHAVIOUR
//  - Reset (rst=1 at edge): wr_ptr=rd_ptr=0, fifo_cnt=0, data_out=0, overflow=underflow=0.
//    This gives empty=1, almost_empty=1, full=0, almost_full=0. Memory contents are not reset.
//    Reset takes effect mid-operation and discards all stored words.
//  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
//  - Flags are decoded from the registered fifo_cnt. They change on the edge after the
//    accepted operation.
//  - Write accepted: wr && (!full || rd_acc). Stores data_in at mem[wr_ptr]; wr_ptr++.
//  - Read accepted (rd_acc): rd && !empty. A read is never accepted from an empty FIFO,
//    even with a simultaneous wr; the written word only becomes readable on the next cycle.
//  - Simultaneous accepted write and read: fifo_cnt unchanged, including at full.
//    Ordering is preserved.
//  - overflow = wr && full && !rd_acc, registered (pulses on the edge after the request).
//    underflow = rd && empty, registered the same way. Rejected operations leave pointers,
//    count and data_out unchanged.
//  - FWFT=0: on an accepted read, data_out <= mem[rd_ptr] at that edge, so the word is valid
//    one cycle after rd. Otherwise data_out holds its last value.
//  - FWFT=1: data_out = mem[rd_ptr] while !empty, else holds the last popped value
//    (0 after reset). A write into an empty FIFO is visible on data_out with empty=0 at the
//    next edge. An accepted rd pops the head, and the next word (or hold) appears after the edge.
//  - fifo_cnt arithmetic: +1 on write-only, -1 on read-only, else hold. It never exceeds
//    DEPTH or goes below 0.
// TESTING (DATA_W=8, DEPTH=16, AF=14, AE=2 unless stated)
//  1 Reset; write 0x00..0x0F on 16 back-to-back cycles, rd=0 ->
//    almost_empty drops after 3rd write; almost_full rises after 14th write;
//    full=1, fifo_cnt=16 after 16th; extra write -> overflow pulse 1 cycle, cnt stays 16.
//  2 From full, FWFT=0: rd for 16 cycles -> data_out 0x00..0x0F, each 1 cycle after its rd;
//    empty=1 after last; extra rd -> underflow pulse, data_out holds 0x0F.
//  3 Simultaneous wr+rd:
//    at cnt=8 -> cnt stays 8, data in order;
//    at full -> both accepted, cnt=16, no overflow;
//    at empty -> write only, underflow pulse, cnt=1.
//  4 Wrap: 48 words (0x30..0x5F), random wr/rd gaps -> scoreboard exact match,
//    pointers wrap at least twice, cnt tracks the model every cycle.
//  5 FWFT=1: write 0xA5 into empty -> next cycle data_out=0xA5, empty=0; write 0x5A then rd ->
//    data_out=0x5A after the edge; rd again -> empty=1, data_out holds 0x5A.
//  6 Reset mid-operation at cnt=9 with wr=rd=1 -> next cycle cnt=0, empty=1, data_out=0,
//    no overflow/underflow; write 0x11 then read -> 0x11 returned.

Source files
------------

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
//   Parametrised single-clock FIFO with almost-full / almost-empty thresholds,
//   registered overflow / underflow error pulses and an optional
//   first-word-fall-through (FWFT) read mode.
//
// Parameters
//   DATA_W     data word width in bits
//   DEPTH      number of entries (power of two, >= 4)
//   AF_THRESH  almost_full  when fifo_cnt >= AF_THRESH
//   AE_THRESH  almost_empty when fifo_cnt <= AE_THRESH
//   FWFT       0 = registered read (data one cycle after rd), 1 = fall-through
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   synchronous active-high reset
//   data_in       in   write data
//   wr            in   write request
//   rd            in   read request
//   data_out      out  read data
//   empty         out  fifo_cnt == 0
//   full          out  fifo_cnt == DEPTH
//   almost_empty  out  fifo_cnt <= AE_THRESH
//   almost_full   out  fifo_cnt >= AF_THRESH
//   fifo_cnt      out  current occupancy, 0..DEPTH
//   overflow      out  one-cycle pulse, a write was rejected
//   underflow     out  one-cycle pulse, a read was rejected
// -----------------------------------------------------------------------------
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       wr,
  input  logic                       rd,
  output logic [DATA_W-1:0]          data_out,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     fifo_cnt,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // last_q is the most recently popped word; it is data_out in registered
  // mode and the hold value in FWFT mode while the FIFO is empty.
  logic [DATA_W-1:0] last_q, last_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              empty_s;
  logic              full_s;
  logic              rd_acc_s;
  logic              wr_acc_s;
  logic [DATA_W-1:0] head_s;

  // Status decode and accept logic, all derived from the registered count.
  always_comb begin
    empty_s  = (cnt_q == {CNT_W{1'b0}});
    full_s   = (cnt_q == CNT_W'(DEPTH));
    head_s   = mem[rd_ptr_q];
    // A read is never accepted from an empty FIFO, so a same-cycle write
    // into an empty FIFO cannot be bypassed to the reader.
    rd_acc_s = rd && !empty_s;
    // A full FIFO still takes a write when a read frees a slot this cycle.
    wr_acc_s = wr && (!full_s || rd_acc_s);
  end

  // Next-state computation for pointers, count, read data and error pulses.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    overflow_d  = wr && full_s && !rd_acc_s;
    underflow_d = rd && empty_s;

    if (wr_acc_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_acc_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      last_d   = head_s;
    end else begin
      rd_ptr_d = rd_ptr_q;
      last_d   = last_q;
    end

    case ({wr_acc_s, rd_acc_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      last_q      <= {DATA_W{1'b0}};
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; contents are intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc_s) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  // Read data path selection.
  generate
    if (FWFT != 0) begin : g_fwft
      // Head word shows as soon as the count says it is present; when empty
      // the last popped word (0 after reset) is held.
      always_comb begin
        if (empty_s) begin
          data_out = last_q;
        end else begin
          data_out = head_s;
        end
      end
    end else begin : g_reg
      // Registered read: the popped word appears one cycle after rd.
      always_comb begin
        data_out = last_q;
      end
    end
  endgenerate

  // Output flag decode.
  always_comb begin
    empty        = empty_s;
    full         = full_s;
    almost_empty = (cnt_q <= CNT_W'(AE_THRESH));
    almost_full  = (cnt_q >= CNT_W'(AF_THRESH));
    fifo_cnt     = cnt_q;
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
//   Directed self-checking bench for sync_fifo_param. Instance u_reg uses the
//   registered read mode, u_fwft the first-word-fall-through mode; both use
//   DATA_W=8, DEPTH=16, AF_THRESH=14, AE_THRESH=2.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din0, din1;
  logic       wr0, rd0, wr1, rd1;

  logic [7:0] dout0, dout1;
  logic       empty0, full0, ae0, af0, ovf0, unf0;
  logic       empty1, full1, ae1, af1, ovf1, unf1;
  logic [4:0] cnt0, cnt1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) u_reg (
    .clk(clk), .rst(rst), .data_in(din0), .wr(wr0), .rd(rd0),
    .data_out(dout0), .empty(empty0), .full(full0),
    .almost_empty(ae0), .almost_full(af0), .fifo_cnt(cnt0),
    .overflow(ovf0), .underflow(unf0)
  );

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .data_in(din1), .wr(wr1), .rd(rd1),
    .data_out(dout1), .empty(empty1), .full(full1),
    .almost_empty(ae1), .almost_full(af1), .fifo_cnt(cnt1),
    .overflow(ovf1), .underflow(unf1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive registered-mode instance for one cycle.
  task automatic op0(input logic w, input logic r, input logic [7:0] d);
    wr0 = w; rd0 = r; din0 = d;
    tick();
    wr0 = 1'b0; rd0 = 1'b0;
  endtask

  // Drive FWFT instance for one cycle.
  task automatic op1(input logic w, input logic r, input logic [7:0] d);
    wr1 = w; rd1 = r; din1 = d;
    tick();
    wr1 = 1'b0; rd1 = 1'b0;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp_d;
    logic       w, r, rd_acc, wr_acc;
    int         pushed, popped, cyc;

    rst = 1'b1; wr0 = 1'b0; rd0 = 1'b0; din0 = 8'h00;
    wr1 = 1'b0; rd1 = 1'b0; din1 = 8'h00;
    tick();
    tick();

    // ---- reset state ----
    chk("rst_cnt",   cnt0,   0);
    chk("rst_empty", empty0, 1);
    chk("rst_ae",    ae0,    1);
    chk("rst_full",  full0,  0);
    chk("rst_af",    af0,    0);
    chk("rst_dout",  dout0,  0);
    chk("rst_ovf",   ovf0,   0);
    chk("rst_unf",   unf0,   0);
    chk("rst_dout1", dout1,  0);
    chk("rst_empty1", empty1, 1);
    rst = 1'b0;

    // ---- 1: fill 0x00..0x0F, thresholds, overflow ----
    for (int i = 0; i < 16; i++) begin
      op0(1'b1, 1'b0, 8'(i));
      chk("t1_cnt",  cnt0, i + 1);
      chk("t1_ae",   ae0,  (i + 1 <= 2)  ? 1 : 0);
      chk("t1_af",   af0,  (i + 1 >= 14) ? 1 : 0);
      chk("t1_full", full0, (i == 15) ? 1 : 0);
    end
    op0(1'b1, 1'b0, 8'hEE);
    chk("t1_ovf_pulse", ovf0, 1);
    chk("t1_ovf_cnt",   cnt0, 16);
    op0(1'b0, 1'b0, 8'h00);
    chk("t1_ovf_clear", ovf0, 0);

    // ---- 2: drain, registered read data, underflow ----
    for (int i = 0; i < 16; i++) begin
      op0(1'b0, 1'b1, 8'h00);
      chk("t2_dout", dout0, i);
      chk("t2_cnt",  cnt0, 15 - i);
    end
    chk("t2_empty", empty0, 1);
    op0(1'b0, 1'b1, 8'h00);
    chk("t2_unf_pulse", unf0, 1);
    chk("t2_unf_hold",  dout0, 8'h0F);
    op0(1'b0, 1'b0, 8'h00);
    chk("t2_unf_clear", unf0, 0);

    // ---- 3a: simultaneous at cnt=8 ----
    for (int i = 0; i < 8; i++) op0(1'b1, 1'b0, 8'(8'h80 + i));
    chk("t3a_cnt_pre", cnt0, 8);
    op0(1'b1, 1'b1, 8'h88);
    chk("t3a_cnt",  cnt0, 8);
    chk("t3a_dout", dout0, 8'h80);
    for (int i = 1; i <= 8; i++) begin
      op0(1'b0, 1'b1, 8'h00);
      chk("t3a_order", dout0, 8'h80 + i);
    end

    // ---- 3b: simultaneous at full ----
    for (int i = 0; i < 16; i++) op0(1'b1, 1'b0, 8'(8'h90 + i));
    chk("t3b_full_pre", full0, 1);
    op0(1'b1, 1'b1, 8'hA0);
    chk("t3b_cnt",  cnt0, 16);
    chk("t3b_ovf",  ovf0, 0);
    chk("t3b_dout", dout0, 8'h90);
    for (int i = 1; i <= 16; i++) begin
      op0(1'b0, 1'b1, 8'h00);
      chk("t3b_order", dout0, 8'h90 + i);
    end

    // ---- 3c: simultaneous at empty ----
    op0(1'b1, 1'b1, 8'hB0);
    chk("t3c_cnt",  cnt0, 1);
    chk("t3c_unf",  unf0, 1);
    chk("t3c_hold", dout0, 8'hA0);
    op0(1'b0, 1'b1, 8'h00);
    chk("t3c_dout", dout0, 8'hB0);
    chk("t3c_cnt0", cnt0, 0);

    // ---- 4: wrap with random gaps against a queue model ----
    pushed = 0; popped = 0; cyc = 0;
    while (popped < 48 && cyc < 2000) begin
      w = (pushed < 48) && ($urandom_range(0, 2) != 0);
      r = (pushed >= 48) || ($urandom_range(0, 2) == 0);
      rd_acc = r && (q.size() > 0);
      wr_acc = w && ((q.size() < 16) || rd_acc);
      exp_d = rd_acc ? q[0] : 8'h00;
      op0(w, r, 8'(8'h30 + pushed));
      if (rd_acc) begin
        chk("t4_data", dout0, exp_d);
        void'(q.pop_front());
        popped++;
      end
      if (wr_acc) begin
        q.push_back(8'(8'h30 + pushed));
        pushed++;
      end
      chk("t4_cnt", cnt0, q.size());
      cyc++;
    end
    chk("t4_done", popped, 48);

    // ---- 5: FWFT ----
    op1(1'b1, 1'b0, 8'hA5);
    chk("t5_dout_a5", dout1, 8'hA5);
    chk("t5_empty",   empty1, 0);
    op1(1'b1, 1'b0, 8'h5A);
    chk("t5_head",    dout1, 8'hA5);
    op1(1'b0, 1'b1, 8'h00);
    chk("t5_dout_5a", dout1, 8'h5A);
    chk("t5_cnt1",    cnt1, 1);
    op1(1'b0, 1'b1, 8'h00);
    chk("t5_empty2",  empty1, 1);
    chk("t5_hold",    dout1, 8'h5A);
    op1(1'b0, 1'b1, 8'h00);
    chk("t5_unf",     unf1, 1);
    chk("t5_hold2",   dout1, 8'h5A);

    // ---- 6: reset mid-operation ----
    for (int i = 0; i < 9; i++) op0(1'b1, 1'b0, 8'(8'hC0 + i));
    chk("t6_cnt_pre", cnt0, 9);
    rst = 1'b1;
    op0(1'b1, 1'b1, 8'hFF);
    rst = 1'b0;
    chk("t6_cnt",   cnt0, 0);
    chk("t6_empty", empty0, 1);
    chk("t6_dout",  dout0, 0);
    chk("t6_ovf",   ovf0, 0);
    chk("t6_unf",   unf0, 0);
    op0(1'b1, 1'b0, 8'h11);
    op0(1'b0, 1'b1, 8'h00);
    chk("t6_readback", dout0, 8'h11);
    chk("t6_cnt_end",  cnt0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
